// File: rtl/seq_divider16.sv
// Iterative unsigned restoring divider: one quotient bit per clock, start/busy/done handshake.
// Results (quotient, remainder, div_by_zero) are registered and only change on the done cycle or reset.
module seq_divider16 #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);

  // Handshake: start is honoured only while busy=0; done is a one-cycle pulse
  // that coincides with the updated result registers.
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_FINISH = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             dz_q, dz_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dzo_q, dzo_d;
  logic             done_q, done_d;

  // A restored partial remainder is always below the divisor, so it fits in
  // WIDTH bits; only the shifted trial value needs the extra bit.
  logic [WIDTH:0]   r_shift;
  logic [WIDTH:0]   trial;

  always_comb begin
    r_shift = {r_q, q_q[WIDTH-1]};
    trial   = r_shift - {1'b0, d_q};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    d_d     = d_q;
    r_d     = r_q;
    dz_d    = dz_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dzo_d   = dzo_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          q_d   = dividend;
          d_d   = divisor;
          r_d   = '0;
          cnt_d = CW'(WIDTH - 1);
          if (divisor == '0) begin
            dz_d    = 1'b1;
            state_d = S_FINISH;
          end else begin
            dz_d    = 1'b0;
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        q_d = {q_q[WIDTH-2:0], ~trial[WIDTH]};
        r_d = trial[WIDTH] ? r_shift[WIDTH-1:0] : trial[WIDTH-1:0];
        if (cnt_q == '0) begin
          state_d = S_FINISH;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_FINISH: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
        if (dz_q) begin
          // q_q still holds the untouched dividend on the divide-by-zero path
          quo_d = '1;
          rem_d = q_q;
          dzo_d = 1'b1;
        end else begin
          quo_d = q_q;
          rem_d = r_q;
          dzo_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      q_q     <= '0;
      d_q     <= '0;
      r_q     <= '0;
      dz_q    <= 1'b0;
      quo_q   <= '0;
      rem_q   <= '0;
      dzo_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      d_q     <= d_d;
      r_q     <= r_d;
      dz_q    <= dz_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dzo_q   <= dzo_d;
      done_q  <= done_d;
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;
  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dzo_q;

endmodule

// File: tb/tb_seq_divider16.sv
// Directed bench for seq_divider16: latency, exact results, divide-by-zero,
// start-while-busy, mid-run reset, back-to-back throughput and a randomised sweep.
module tb_seq_divider16;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] dividend;
  logic [15:0] divisor;
  logic        busy;
  logic        done;
  logic [15:0] quotient;
  logic [15:0] remainder;
  logic        div_by_zero;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;
  int cyc     = 0;

  logic [15:0] r_quo, r_rem;
  logic        r_dz;
  int          r_lat, r_busy;
  bit          r_ok;

  seq_divider16 #(.WIDTH(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drives a start for one edge from the current time; returns at #1 after that edge.
  task automatic launch(input logic [15:0] a, input logic [15:0] b);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    r_lat  = 0;
    r_busy = busy ? 1 : 0;
    r_ok   = 1'b0;
    while (r_lat < limit && !r_ok) begin
      @(posedge clk);
      #1;
      r_lat++;
      if (busy) r_busy++;
      if (done) r_ok = 1'b1;
    end
    if (r_ok) begin
      r_quo = quotient;
      r_rem = remainder;
      r_dz  = div_by_zero;
    end
  endtask

  task automatic do_div(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] eq, input logic [15:0] er, input logic edz,
                        input int elat);
    @(negedge clk);
    launch(a, b);
    wait_done(40);
    chk($sformatf("%s done", tag), r_ok, 1);
    if (r_ok) begin
      chk($sformatf("%s latency", tag), r_lat, elat);
      chk($sformatf("%s quotient", tag), r_quo, eq);
      chk($sformatf("%s remainder", tag), r_rem, er);
      chk($sformatf("%s dz", tag), r_dz, edz);
    end
  endtask

  initial begin
    int n_done;
    int last_done;
    logic [15:0] a, b;

    rst      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset quotient", quotient, 0);
    chk("reset remainder", remainder, 0);
    chk("reset dz", div_by_zero, 0);
    @(negedge clk);
    rst = 1'b0;

    // 100 / 7 with latency and busy-length checks
    @(negedge clk);
    launch(16'd100, 16'd7);
    wait_done(40);
    chk("100/7 done", r_ok, 1);
    chk("100/7 latency", r_lat, 17);
    chk("100/7 busy cycles", r_busy, 17);
    chk("100/7 quotient", r_quo, 14);
    chk("100/7 remainder", r_rem, 2);
    chk("100/7 dz", r_dz, 0);
    chk("100/7 busy at done", busy, 0);
    @(posedge clk);
    #1;
    chk("100/7 done pulse width", done, 0);

    do_div("ffff/1", 16'hFFFF, 16'd1, 16'hFFFF, 16'd0, 1'b0, 17);
    do_div("ffff/ffff", 16'hFFFF, 16'hFFFF, 16'd1, 16'd0, 1'b0, 17);
    do_div("3/10", 16'd3, 16'd10, 16'd0, 16'd3, 1'b0, 17);

    // divide by zero, then a normal op clears the flag
    @(negedge clk);
    launch(16'd5, 16'd0);
    wait_done(40);
    chk("5/0 done", r_ok, 1);
    chk("5/0 latency", r_lat, 1);
    chk("5/0 busy cycles", r_busy, 1);
    chk("5/0 quotient", r_quo, 16'hFFFF);
    chk("5/0 remainder", r_rem, 5);
    chk("5/0 dz", r_dz, 1);
    do_div("9/3", 16'd9, 16'd3, 16'd3, 16'd0, 1'b0, 17);

    // start pulses while busy must be ignored
    @(negedge clk);
    launch(16'd1000, 16'd9);
    n_done = 0;
    for (int k = 1; k <= 17; k++) begin
      if (k == 3 || k == 17) begin
        dividend = 16'd50;
        divisor  = 16'd5;
        start    = 1'b1;
      end else begin
        dividend = 16'd777;
        divisor  = 16'd13;
        start    = 1'b0;
      end
      @(posedge clk);
      #1;
      if (done) begin
        n_done++;
        chk("1000/9 done edge", k, 17);
      end
    end
    start = 1'b0;
    chk("1000/9 done count", n_done, 1);
    chk("1000/9 quotient", quotient, 111);
    chk("1000/9 remainder", remainder, 1);
    chk("1000/9 dz", div_by_zero, 0);
    n_done = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1;
      if (done) n_done++;
      chk("hold busy", busy, 0);
      chk("hold quotient", quotient, 111);
      chk("hold remainder", remainder, 1);
    end
    chk("hold no done", n_done, 0);

    // reset in the middle of a run aborts and clears outputs
    @(negedge clk);
    launch(16'd40000, 16'd123);
    repeat (7) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("abort busy", busy, 0);
    chk("abort done", done, 0);
    chk("abort quotient", quotient, 0);
    chk("abort remainder", remainder, 0);
    chk("abort dz", div_by_zero, 0);
    n_done = 0;
    for (int k = 0; k < 25; k++) begin
      @(posedge clk);
      #1;
      if (done) n_done++;
    end
    chk("abort no done", n_done, 0);
    do_div("40000/123", 16'd40000, 16'd123, 16'd325, 16'd25, 1'b0, 17);

    // back-to-back: new start presented in the done cycle
    @(negedge clk);
    launch(16'd200, 16'd3);
    last_done = 0;
    for (int i = 0; i < 4; i++) begin
      wait_done(40);
      chk("b2b done", r_ok, 1);
      chk("b2b quotient", r_quo, 66);
      chk("b2b remainder", r_rem, 2);
      if (i > 0) chk("b2b period", cyc - last_done, 18);
      last_done = cyc;
      if (i < 3) launch(16'd200, 16'd3);
    end

    // randomised sweep against a behavioural reference
    for (int i = 0; i < 1000; i++) begin
      a = 16'($urandom_range(0, 65535));
      if (i % 50 == 7)     b = 16'd0;
      else if (i % 3 == 0) b = 16'($urandom_range(1, 255));
      else                 b = 16'($urandom_range(1, 65535));
      if (b == 16'd0) do_div($sformatf("rnd%0d", i), a, b, 16'hFFFF, a, 1'b1, 1);
      else            do_div($sformatf("rnd%0d", i), a, b, a / b, a % b, 1'b0, 17);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
